// File: rtl/alu_op_dispatcher_pkg.sv
// Shared definitions for the ALU operation dispatcher: unit-select codes,
// logic-unit function codes, FSM state encoding and the default data width.
package alu_dispatch_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // cmd_fun[3:2] unit selection
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    // cmd_fun[1:0] when the logic unit is selected
    localparam logic [1:0] LOGIC_AND  = 2'b00;
    localparam logic [1:0] LOGIC_OR   = 2'b01;
    localparam logic [1:0] LOGIC_NAND = 2'b10;
    localparam logic [1:0] LOGIC_NOR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    // Decode a unit-select code into a one-hot enable vector
    // (bit 0 arith, bit 1 logic, bit 2 cmp, bit 3 shift).
    function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        case (sel)
            UNIT_ARITH: oh = 4'b0001;
            UNIT_LOGIC: oh = 4'b0010;
            UNIT_CMP:   oh = 4'b0100;
            UNIT_SHIFT: oh = 4'b1000;
            default:    oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/alu_op_dispatcher_if.sv
// Command / response handshake bundle of the ALU operation dispatcher.
// master: the side issuing commands and consuming responses.
// slave:  the dispatcher itself.
interface alu_dispatch_if
    import alu_dispatch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [3:0]       cmd_fun;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_op_dispatcher_unit_select.sv
// Combinational unit selector: turns the captured select code plus the
// "enable active" bit into one-hot unit enables, and routes the selected
// unit's result/flag back to the dispatcher FSM.
module alu_unit_select
    import alu_dispatch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       sel_i,
    input  logic             active_i,
    input  logic [WIDTH-1:0] arith_out_i,
    input  logic [WIDTH-1:0] logic_out_i,
    input  logic [WIDTH-1:0] cmp_out_i,
    input  logic [WIDTH-1:0] shift_out_i,
    input  logic             arith_flag_i,
    input  logic             logic_flag_i,
    input  logic             cmp_flag_i,
    input  logic             shift_flag_i,
    output logic [3:0]       en_o,
    output logic [WIDTH-1:0] out_o,
    output logic             flag_o
);

    // Gate the one-hot decode with the active bit so no enable leaks in IDLE/RESP
    always_comb begin
        if (active_i) begin
            en_o = unit_onehot(sel_i);
        end else begin
            en_o = 4'b0000;
        end
    end

    // Return path mux: only the selected unit's result and flag are visible
    always_comb begin
        out_o  = {WIDTH{1'b0}};
        flag_o = 1'b0;
        case (sel_i)
            UNIT_ARITH: begin out_o = arith_out_i; flag_o = arith_flag_i; end
            UNIT_LOGIC: begin out_o = logic_out_i; flag_o = logic_flag_i; end
            UNIT_CMP:   begin out_o = cmp_out_i;   flag_o = cmp_flag_i;   end
            UNIT_SHIFT: begin out_o = shift_out_i; flag_o = shift_flag_i; end
            default:    begin out_o = {WIDTH{1'b0}}; flag_o = 1'b0;       end
        endcase
    end

endmodule

// File: rtl/alu_op_dispatcher.sv
// ALU operation dispatcher: accepts one command, drives exactly one execution
// unit until its flag returns (or a timeout expires), then holds the result on
// the response port until it is consumed.
// Optional build macro DISPATCH_STATS_EN adds saturating op/error counters.
module alu_op_dispatcher
    import alu_dispatch_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    alu_dispatch_if.slave    bus,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic [1:0]       unit_fun,
    output logic             arith_en,
    output logic             logic_en,
    output logic             cmp_en,
    output logic             shift_en,
    input  logic [WIDTH-1:0] arith_out,
    input  logic [WIDTH-1:0] logic_out,
    input  logic [WIDTH-1:0] cmp_out,
    input  logic [WIDTH-1:0] shift_out,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]      op_count,
    output logic [7:0]       err_count
`endif
);

    // 9-bit so the compare against the incremented 8-bit counter cannot wrap
    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d;
    logic [WIDTH-1:0] unit_b_q, unit_b_d;
    logic [1:0]       unit_fun_q, unit_fun_d;
    logic             active_q, active_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [8:0]       cnt_inc_s;
    logic [3:0]       en_s;
    logic [WIDTH-1:0] sel_out_s;
    logic             sel_flag_s;

    alu_unit_select #(.WIDTH(WIDTH)) u_sel (
        .sel_i        (sel_q),
        .active_i     (active_q),
        .arith_out_i  (arith_out),
        .logic_out_i  (logic_out),
        .cmp_out_i    (cmp_out),
        .shift_out_i  (shift_out),
        .arith_flag_i (arith_flag),
        .logic_flag_i (logic_flag),
        .cmp_flag_i   (cmp_flag),
        .shift_flag_i (shift_flag),
        .en_o         (en_s),
        .out_o        (sel_out_s),
        .flag_o       (sel_flag_s)
    );

    assign cnt_inc_s = {1'b0, cnt_q} + 9'd1;

    // Next-state and datapath updates for the IDLE/ISSUE/WAIT/RESP sequence
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        unit_a_d    = unit_a_q;
        unit_b_d    = unit_b_q;
        unit_fun_d  = unit_fun_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    unit_a_d   = bus.cmd_a;
                    unit_b_d   = bus.cmd_b;
                    unit_fun_d = bus.cmd_fun[1:0];
                    sel_d      = bus.cmd_fun[3:2];
                    active_d   = 1'b1;
                    state_d    = S_ISSUE;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A flag arriving on the final counted cycle still wins over timeout
                if (sel_flag_s) begin
                    rsp_data_d  = sel_out_s;
                    rsp_err_d   = 1'b0;
                    active_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    cnt_d       = cnt_inc_s[7:0];
                    rsp_data_d  = {WIDTH{1'b0}};
                    rsp_err_d   = 1'b1;
                    active_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d       = cnt_inc_s[7:0];
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d     = S_RESP;
                end
            end
            default: begin
                active_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'b00;
            unit_a_q    <= {WIDTH{1'b0}};
            unit_b_q    <= {WIDTH{1'b0}};
            unit_fun_q  <= 2'b00;
            active_q    <= 1'b0;
            cnt_q       <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            unit_a_q    <= unit_a_d;
            unit_b_q    <= unit_b_d;
            unit_fun_q  <= unit_fun_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign unit_a        = unit_a_q;
    assign unit_b        = unit_b_q;
    assign unit_fun      = unit_fun_q;
    assign arith_en      = en_s[0];
    assign logic_en      = en_s[1];
    assign cmp_en        = en_s[2];
    assign shift_en      = en_s[3];

`ifdef DISPATCH_STATS_EN
    logic [15:0] op_cnt_q;
    logic [7:0]  err_cnt_q;
    logic        hs_s;

    assign hs_s = rsp_valid_q && bus.rsp_ready;

    // Saturating response / error counters, bumped on each response handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            op_cnt_q  <= 16'd0;
            err_cnt_q <= 8'd0;
        end else begin
            if (hs_s && (op_cnt_q != 16'hFFFF)) begin
                op_cnt_q <= op_cnt_q + 16'd1;
            end
            if (hs_s && rsp_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench for alu_op_dispatcher with simple behavioural unit models.
module tb_alu_op_dispatcher;
    import alu_dispatch_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_dispatch_if #(.WIDTH(W)) bus();

    logic [W-1:0] unit_a, unit_b;
    logic [1:0]   unit_fun;
    logic         arith_en, logic_en, cmp_en, shift_en;
    logic [W-1:0] arith_out, logic_out, cmp_out, shift_out;
    logic         arith_flag, logic_flag, cmp_flag, shift_flag;
    logic         cmp_flag_r;
    logic         shift_dead, cmp_manual, cmp_man;
`ifdef DISPATCH_STATS_EN
    logic [15:0]  op_count;
    logic [7:0]   err_count;
`endif

    alu_op_dispatcher #(.WIDTH(W), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_fun   (unit_fun),
        .arith_en   (arith_en),
        .logic_en   (logic_en),
        .cmp_en     (cmp_en),
        .shift_en   (shift_en),
        .arith_out  (arith_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag)
`ifdef DISPATCH_STATS_EN
        ,
        .op_count   (op_count),
        .err_count  (err_count)
`endif
    );

    function automatic logic [W-1:0] logic_ref(input logic [1:0] f, input logic [W-1:0] a, b);
        case (f)
            LOGIC_AND:  return a & b;
            LOGIC_OR:   return a | b;
            LOGIC_NAND: return ~(a & b);
            LOGIC_NOR:  return ~(a | b);
            default:    return '0;
        endcase
    endfunction

    // Single-cycle registered execution-unit models
    always @(posedge clk) begin
        if (reset) begin
            arith_flag <= 1'b0; logic_flag <= 1'b0; cmp_flag_r <= 1'b0; shift_flag <= 1'b0;
            arith_out  <= '0;   logic_out  <= '0;   cmp_out    <= '0;   shift_out  <= '0;
        end else begin
            arith_flag <= arith_en;
            logic_flag <= logic_en;
            cmp_flag_r <= cmp_en;
            shift_flag <= shift_en & ~shift_dead;
            if (arith_en) arith_out <= (unit_fun == 2'b00) ? unit_a + unit_b : unit_a - unit_b;
            if (logic_en) logic_out <= logic_ref(unit_fun, unit_a, unit_b);
            if (cmp_en)   cmp_out   <= {15'd0, unit_a == unit_b};
            if (shift_en) shift_out <= unit_a << unit_b[3:0];
        end
    end

    assign cmp_flag = cmp_manual ? cmp_man : cmp_flag_r;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command with rsp_ready=1; report result, latency and stray enables
    task automatic do_op(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] data, output logic err, output int lat,
                         output logic [3:0] stray);
        logic [3:0] mask;
        mask = 4'b0001 << fun[3:2];
        bus.cmd_fun = fun; bus.cmd_a = a; bus.cmd_b = b;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
        lat = 0; stray = 4'b0000;
        tick();
        bus.cmd_valid = 1'b0;
        while (!bus.rsp_valid && lat < 40) begin
            stray |= {shift_en, cmp_en, logic_en, arith_en} & ~mask;
            tick();
            lat++;
        end
        data = bus.rsp_data;
        err  = bus.rsp_err;
        tick();
    endtask

    logic [W-1:0] d;
    logic         e;
    logic [3:0]   stray;
    int           lat, cnt, n;
    logic         ok;

    initial begin
        reset = 1'b1; shift_dead = 1'b0; cmp_manual = 1'b0; cmp_man = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_fun = 4'd0;
        bus.rsp_ready = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_enables",   32'({arith_en, logic_en, cmp_en, shift_en}), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data), 32'd0);
        check("rst_unit_a",    32'(unit_a), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Logic AND, cycle by cycle
        bus.cmd_fun = 4'b0100; bus.cmd_a = 16'h00F0; bus.cmd_b = 16'h0FF0;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
        tick();
        check("and_issue_en",    32'(logic_en), 32'd1);
        check("and_unit_a",      32'(unit_a), 32'h00F0);
        check("and_unit_b",      32'(unit_b), 32'h0FF0);
        check("and_unit_fun",    32'(unit_fun), 32'd0);
        check("and_busy_ready",  32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;
        tick();
        check("and_wait_en",     32'(logic_en), 32'd1);
        check("and_wait_valid",  32'(bus.rsp_valid), 32'd0);
        tick();
        check("and_rsp_valid",   32'(bus.rsp_valid), 32'd1);
        check("and_rsp_data",    32'(bus.rsp_data), 32'h00F0);
        check("and_rsp_err",     32'(bus.rsp_err), 32'd0);
        check("and_rsp_en_off",  32'(logic_en), 32'd0);
        tick();
        check("and_done_valid",  32'(bus.rsp_valid), 32'd0);
        check("and_done_ready",  32'(bus.cmd_ready), 32'd1);

        // Logic NOR, with other units required to stay idle
        do_op(4'b0111, 16'h0000, 16'h0001, d, e, lat, stray);
        check("nor_data",  32'(d), 32'hFFFE);
        check("nor_err",   32'(e), 32'd0);
        check("nor_stray", 32'(stray), 32'd0);
        check("nor_lat",   32'(lat), 32'd2);

        // Arith subtract
        do_op(4'b0001, 16'h0010, 16'h0001, d, e, lat, stray);
        check("sub_data",  32'(d), 32'h000F);
        check("sub_stray", 32'(stray), 32'd0);

        // Backpressure with a second command pending
        bus.rsp_ready = 1'b0;
        bus.cmd_fun = 4'b0000; bus.cmd_a = 16'h1234; bus.cmd_b = 16'h0001; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_fun = 4'b0101; bus.cmd_a = 16'h0F00; bus.cmd_b = 16'h00F0;
        tick(); tick();
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        ok = 1'b1;
        repeat (5) begin
            if (!(bus.rsp_valid && bus.rsp_data == 16'h1235 && !bus.cmd_ready && !logic_en)) ok = 1'b0;
            tick();
        end
        check("bp_stable",    32'(ok), 32'd1);
        check("bp_data",      32'(bus.rsp_data), 32'h1235);
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_hs_valid",  32'(bus.rsp_valid), 32'd0);
        check("bp_hs_ready",  32'(bus.cmd_ready), 32'd1);
        check("bp_hs_noen",   32'(logic_en), 32'd0);
        tick();
        check("bp_2nd_en",    32'(logic_en), 32'd1);
        check("bp_2nd_a",     32'(unit_a), 32'h0F00);
        bus.cmd_valid = 1'b0;
        tick(); tick();
        check("bp_2nd_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_2nd_data",  32'(bus.rsp_data), 32'h0FF0);
        tick();

        // Timeout on a dead shift unit
        shift_dead = 1'b1;
        bus.cmd_fun = 4'b1100; bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0004; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        cnt = 0; n = 0;
        while (!bus.rsp_valid && n < 40) begin
            if (shift_en) cnt++;
            tick();
            n++;
        end
        check("to_en_cycles", 32'(cnt), 32'd16);
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("to_rsp_err",   32'(bus.rsp_err), 32'd1);
        check("to_rsp_data",  32'(bus.rsp_data), 32'h0000);
        check("to_en_off",    32'(shift_en), 32'd0);
        tick();
        shift_dead = 1'b0;

        // Flag arriving on the last allowed WAIT cycle beats the timeout
        cmp_manual = 1'b1; cmp_man = 1'b0;
        bus.cmd_fun = 4'b1000; bus.cmd_a = 16'h0005; bus.cmd_b = 16'h0005; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        repeat (14) tick();
        check("fw_still_wait", 32'({bus.rsp_valid, cmp_en}), 32'b01);
        cmp_man = 1'b1;
        tick();
        check("fw_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        check("fw_rsp_err",    32'(bus.rsp_err), 32'd0);
        check("fw_rsp_data",   32'(bus.rsp_data), 32'h0001);
        cmp_man = 1'b0; cmp_manual = 1'b0;
        tick();

        // Reset mid-WAIT discards the in-flight command
        shift_dead = 1'b1;
        bus.cmd_fun = 4'b1100; bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0001; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick(); tick();
        check("mr_wait_en",   32'(shift_en), 32'd1);
        reset = 1'b1;
        tick();
        check("mr_en_off",    32'({arith_en, logic_en, cmp_en, shift_en}), 32'd0);
        check("mr_valid_off", 32'(bus.rsp_valid), 32'd0);
        check("mr_ready_low", 32'(bus.cmd_ready), 32'd0);
        reset = 1'b0;
        ok = 1'b0;
        repeat (20) begin
            ok |= bus.rsp_valid;
            tick();
        end
        check("mr_no_rsp",    32'(ok), 32'd0);
        shift_dead = 1'b0;
        do_op(4'b0101, 16'h0F00, 16'h00F0, d, e, lat, stray);
        check("mr_or_data",   32'(d), 32'h0FF0);
        check("mr_or_err",    32'(e), 32'd0);

`ifdef DISPATCH_STATS_EN
        // 8 completed responses so far, one of them a timeout
        check("st_op_count",  32'(op_count), 32'd8);
        check("st_err_count", 32'(err_count), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("st_op_rst",    32'(op_count), 32'd0);
        check("st_err_rst",   32'(err_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
Command-side initiator for the hierarchical ALU's execution units (arith, logic, compare, shift). It accepts one operation per valid/ready command and decodes the 4-bit function code into a single unit enable plus a 2-bit unit function. It holds the enable until that unit's flag returns, then presents the captured result on a valid/ready response port. It sits between the ALU top-level command interface and the four registered execution units.

Parameters:
WIDTH, 16, operand/result width; matches the execution units.
TIMEOUT, 15, maximum WAIT cycles allowed for the selected unit's flag; legal range 1..255.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  dispatcher can accept a command
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_fun  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit function
unit_a  out  WIDTH  registered operand A to all units
unit_b  out  WIDTH  registered operand B to all units
unit_fun  out  2  registered cmd_fun[1:0]
arith_en, logic_en, cmp_en, shift_en  out  1 each  unit enables, at most one high
arith_out, logic_out, cmp_out, shift_out  in  WIDTH each  unit results
arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  unit result-valid flags
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  captured result
rsp_err  out  1  timeout indicator for this response

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all enables 0; unit_a/unit_b/unit_fun 0; rsp_valid 0; rsp_data 0; rsp_err 0; timeout counter 0. cmd_ready is forced 0 while reset is high.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_a, cmd_b and cmd_fun into unit_a, unit_b, unit_fun and the select register. Next state is ISSUE.
  - ISSUE: only the selected enable is high and the unit samples the operands. Clear the counter. Next state is WAIT.
  - WAIT: the selected enable stays high.
    - If the selected flag is 1, capture the selected *_out into rsp_data, set rsp_err=0, drop the enable and go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT, set rsp_data=0, rsp_err=1, drop the enable and go to RESP.
    - If the flag and counter==TIMEOUT occur in the same cycle, the flag wins (no error).
  - RESP: rsp_valid=1. rsp_data and rsp_err stay stable until rsp_valid&rsp_ready, then go to IDLE and drop rsp_valid at that edge.
- Flags of non-selected units are ignored. Operands and unit_fun stay stable from ISSUE through WAIT.
- Latency with single-cycle units: command accepted at edge T, enable high in cycle T+1, flag seen in T+2, rsp_valid in T+3. Minimum command-to-command spacing is 4 cycles.
- cmd_ready=0 in ISSUE, WAIT and RESP; a cmd_valid held during that time is accepted on the first IDLE cycle.
- Reset mid-operation: at the next edge all enables and rsp_valid drop and state returns to IDLE; any in-flight command is discarded with no response.
- Counter width is 8 bits.

Optional Feature:
Macro DISPATCH_STATS_EN.
- Defined:
  - Adds output op_count[15:0], incremented on every response handshake.
  - Adds output err_count[7:0], incremented on handshakes with rsp_err=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_dispatch_pkg holds:
  - unit-select constants UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11;
  - logic-unit function codes AND=00, OR=01, NAND=10, NOR=11;
  - the state encoding IDLE/ISSUE/WAIT/RESP;
  - the default WIDTH.
- One sub-module, alu_unit_select: combinational. It maps the select register plus an enable-active bit to the four one-hot enables, and muxes the selected *_out/*_flag pair back to the FSM.

Test Plan:
1. Logic AND: cmd_fun=4'b0100, A=0x00F0, B=0x0FF0, rsp_ready=1 -> logic_en high in T+1 only through WAIT; rsp_valid at T+3 with rsp_data=0x00F0, rsp_err=0.
2. Logic NOR: cmd_fun=4'b0111, A=0x0000, B=0x0001 -> rsp_data=0xFFFE; arith_en, cmp_en and shift_en stay 0 throughout.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with a second cmd_valid pending -> rsp_valid/rsp_data stable, cmd_ready=0. The second command is accepted the cycle after the handshake.
4. Timeout: shift_flag tied 0, cmd_fun=4'b1100, TIMEOUT=15 -> shift_en high for ISSUE plus 15 WAIT cycles, then rsp_valid with rsp_err=1 and rsp_data=0x0000.
5. Reset mid-WAIT: assert reset for 1 cycle during WAIT -> next edge: all enables 0, rsp_valid 0, no response emitted. A following OR command (A=0x0F00, B=0x00F0) returns 0x0FF0.
6. Stats (DISPATCH_STATS_EN defined): 3 normal ops plus 1 timeout -> op_count=4, err_count=1. After reset both are 0.
